// File: rtl/perf_mon_pkg.sv
// Shared constants for the performance event monitor:
// event channel indices and default parameter values.
package perf_mon_pkg;

   localparam int EV_STALL   = 0;
   localparam int EV_BRANCH  = 1;
   localparam int EV_FWDA    = 2;
   localparam int EV_FWDB    = 3;
   localparam int EV_LOADUSE = 4;
   localparam int EV_FLUSH   = 5;

   localparam int DEF_NUM_EV   = 6;
   localparam int DEF_CNT_W    = 32;
   localparam int DEF_SAT      = 0;
   localparam int DEF_TR_DEPTH = 8;
   localparam int DEF_TS_W     = 16;

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through trace FIFO with async-high reset and sync clear.
// Ports: clk, rst, clr, push/din in; pop in; valid/dout head out; drop out.
module trace_fifo #(
   parameter int W     = 22,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         valid,
   output logic [W-1:0] dout,
   output logic         drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  r_wp;
   logic [AW:0]  r_rp;
   logic [W-1:0] r_mem [DEPTH];

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   // Extra pointer MSB distinguishes full from empty.
   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                    (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_pop   = pop && !w_empty;
   // A pop frees the slot this edge, so push-while-full is legal then.
   assign w_push  = push && (!w_full || w_pop);
   assign drop    = push && w_full && !w_pop;

   assign valid = !w_empty;
   assign dout  = w_empty ? '0 : r_mem[r_rp[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp <= '0;
         r_rp <= '0;
      end else if (clr) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !clr) r_mem[r_wp[AW-1:0]] <= din;
   end

endmodule

// File: rtl/perf_event_monitor.sv
// Per-channel event counters plus cycle counter, snapshot shadows, trace FIFO.
// Ports: en/clr/ev_i/snap control; rd_sel->rd_data shadow read; tr_* trace.
module perf_event_monitor
   import perf_mon_pkg::*;
#(
   parameter int NUM_EV   = DEF_NUM_EV,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int SAT      = DEF_SAT,
   parameter int TR_DEPTH = DEF_TR_DEPTH,
   parameter int TS_W     = DEF_TS_W,
   localparam int SW      = $clog2(NUM_EV + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr,
   input  logic [NUM_EV-1:0]      ev_i,
   input  logic                   snap,
   input  logic [SW-1:0]          rd_sel,
   output logic [CNT_W-1:0]       rd_data,
   input  logic                   tr_pop,
   output logic                   tr_valid,
   output logic [TS_W+NUM_EV-1:0] tr_data,
   output logic                   tr_ovf
);

   localparam logic [SW-1:0] MAX_SEL = SW'(NUM_EV);

   // Index NUM_EV holds the cycle counter.
   logic [CNT_W-1:0] r_cnt [NUM_EV+1];
   logic [CNT_W-1:0] r_shd [NUM_EV+1];
   logic             r_ovf;

   logic [NUM_EV:0]  w_hit;
   logic             w_push;
   logic             w_drop;
   logic [TS_W+NUM_EV-1:0] w_din;

   function automatic logic [CNT_W-1:0] bump(
      input logic [CNT_W-1:0] v,
      input logic             hit
   );
      if (!hit)                 return v;
      if ((SAT != 0) && (&v))   return v;
      return v + 1'b1;
   endfunction

   assign w_hit  = {en, ev_i & {NUM_EV{en}}};
   assign w_push = en && (|ev_i);
   assign w_din  = {r_cnt[NUM_EV][TS_W-1:0], ev_i};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= NUM_EV; i++) begin
            r_cnt[i] <= '0;
            r_shd[i] <= '0;
         end
      end else begin
         for (int i = 0; i <= NUM_EV; i++) begin
            if (clr) r_cnt[i] <= '0;
            else     r_cnt[i] <= bump(r_cnt[i], w_hit[i]);
            // Shadows take the pre-edge value and ignore clr.
            if (snap) r_shd[i] <= r_cnt[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_ovf <= 1'b0;
      else if (clr)    r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
   end

   always_comb begin
      rd_data = '0;
      if (rd_sel <= MAX_SEL) rd_data = r_shd[rd_sel];
   end

   assign tr_ovf = r_ovf;

   trace_fifo #(
      .W     (TS_W + NUM_EV),
      .DEPTH (TR_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (w_push),
      .din   (w_din),
      .pop   (tr_pop),
      .valid (tr_valid),
      .dout  (tr_data),
      .drop  (w_drop)
   );

endmodule

// File: tb/tb_perf_event_monitor.sv
// Scoreboard bench: stimulus queues expectations, a negedge monitor checks.
// Three instances share stimulus: default, 8-bit wrapping, 8-bit saturating.
module tb_perf_event_monitor;

   localparam int NE = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic clr = 1'b0;
   logic snap = 1'b0;
   logic tr_pop = 1'b0;
   logic [NE-1:0] ev_i = '0;
   logic [2:0] rd_sel = '0;

   logic [31:0] rd_data;
   logic        tr_valid;
   logic [21:0] tr_data;
   logic        tr_ovf;

   logic [7:0]  rd_w;
   logic        trv_w;
   logic [13:0] trd_w;
   logic        ovf_w;
   logic [7:0]  rd_s;
   logic        trv_s;
   logic [13:0] trd_s;
   logic        ovf_s;

   always #5 clk = ~clk;

   perf_event_monitor u_dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ev_i(ev_i),
      .snap(snap), .rd_sel(rd_sel), .rd_data(rd_data),
      .tr_pop(tr_pop), .tr_valid(tr_valid), .tr_data(tr_data),
      .tr_ovf(tr_ovf)
   );

   perf_event_monitor #(.CNT_W(8), .SAT(0), .TS_W(8)) u_w8 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ev_i(ev_i),
      .snap(snap), .rd_sel(rd_sel), .rd_data(rd_w),
      .tr_pop(tr_pop), .tr_valid(trv_w), .tr_data(trd_w),
      .tr_ovf(ovf_w)
   );

   perf_event_monitor #(.CNT_W(8), .SAT(1), .TS_W(8)) u_s8 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ev_i(ev_i),
      .snap(snap), .rd_sel(rd_sel), .rd_data(rd_s),
      .tr_pop(tr_pop), .tr_valid(trv_s), .tr_data(trd_s),
      .tr_ovf(ovf_s)
   );

   typedef enum int {K_RD, K_RDW, K_RDS, K_TRV, K_TRD, K_OVF} kind_t;

   typedef struct {
      kind_t       kind;
      string       name;
      logic [63:0] exp;
   } chk_t;

   chk_t        cq[$];
   logic [21:0] tq[$];
   int          nvec = 0;
   int          nerr = 0;

   always @(negedge clk) begin
      chk_t        c;
      logic [63:0] act;
      logic [21:0] e;
      while (cq.size() > 0) begin
         c = cq.pop_front();
         act = '0;
         case (c.kind)
            K_RD:  act = 64'(rd_data);
            K_RDW: act = 64'(rd_w);
            K_RDS: act = 64'(rd_s);
            K_TRV: act = 64'(tr_valid);
            K_TRD: act = 64'(tr_data);
            K_OVF: act = 64'(tr_ovf);
            default: act = '0;
         endcase
         nvec++;
         if (act !== c.exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
         end
      end
      if (tr_pop && tr_valid) begin
         nvec++;
         if (tq.size() == 0) begin
            nerr++;
            $display("FAIL trace_pop: got %0h expected no entry", tr_data);
         end else begin
            e = tq.pop_front();
            if (tr_data !== e) begin
               nerr++;
               $display("FAIL trace_pop: got %0h expected %0h", tr_data, e);
            end
         end
      end else if (tr_pop && !tr_valid && tq.size() > 0) begin
         nvec++;
         nerr++;
         e = tq.pop_front();
         $display("FAIL trace_pop: got empty expected %0h", e);
      end
   end

   task automatic expect_v(kind_t k, logic [63:0] v, string n);
      chk_t c;
      c.kind = k;
      c.name = n;
      c.exp  = v;
      cq.push_back(c);
   endtask

   task automatic step(logic e, logic [NE-1:0] ev, logic s, logic c, logic p);
      en = e;
      ev_i = ev;
      snap = s;
      clr = c;
      tr_pop = p;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(kind_t k, logic [2:0] sel, logic [63:0] v, string n);
      rd_sel = sel;
      expect_v(k, v, n);
      idle();
   endtask

   task automatic ev_push(logic [NE-1:0] ev, int ts);
      tq.push_back({16'(ts), ev});
      step(1'b1, ev, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop_one();
      expect_v(K_TRV, 1, "pop_valid");
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      idle();
      idle();
      expect_v(K_TRV, 0, "rst_trv");
      expect_v(K_TRD, 0, "rst_trd");
      expect_v(K_OVF, 0, "rst_ovf");
      chk(K_RD, 3'd0, 0, "rst_rd0");
      rst = 1'b0;
      chk(K_RD, 3'd6, 0, "rst_rdcyc");

      // 10 enabled cycles, channel 0 hit on the first 3
      for (int i = 0; i < 10; i++) begin
         if (i < 3) ev_push(6'b000001, i);
         else       step(1'b1, '0, 1'b0, 1'b0, 1'b0);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk(K_RD, 3'd0, 3, "snap_ev0");
      chk(K_RD, 3'd6, 10, "snap_cyc");
      chk(K_RD, 3'd1, 0, "snap_ev1");
      chk(K_RD, 3'd7, 0, "sel_oob");
      for (int i = 0; i < 3; i++) pop_one();
      chk(K_TRV, 3'd0, 0, "t1_empty");

      // 257 branch cycles: wrap vs saturate at 8 bits
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 257; i++)
         step(1'b1, 6'b000010, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk(K_RDW, 3'd1, 1, "w8_ev1");
      chk(K_RDS, 3'd1, 255, "s8_ev1");
      chk(K_RDW, 3'd6, 1, "w8_cyc");
      chk(K_RDS, 3'd6, 255, "s8_cyc");
      chk(K_RD, 3'd1, 257, "w32_ev1");
      chk(K_OVF, 3'd0, 1, "t2_ovf");
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      expect_v(K_TRV, 0, "clr_trv");
      chk(K_OVF, 3'd0, 0, "clr_ovf");

      // 9 pushes into depth 8, no pop
      for (int i = 0; i < 8; i++) ev_push(6'b000100, i);
      step(1'b1, 6'b000100, 1'b0, 1'b0, 1'b0);
      expect_v(K_TRV, 1, "t3_trv");
      chk(K_OVF, 3'd0, 1, "t3_ovf");
      for (int i = 0; i < 8; i++) pop_one();
      expect_v(K_OVF, 1, "t3_ovf_sticky");
      chk(K_TRV, 3'd0, 0, "t3_empty");

      // push and pop together while full
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) ev_push(6'b001000, i);
      expect_v(K_TRV, 1, "t4_pp_valid");
      tq.push_back({16'd8, 6'b001000});
      step(1'b1, 6'b001000, 1'b0, 1'b0, 1'b1);
      chk(K_OVF, 3'd0, 0, "t4_no_ovf");
      for (int i = 0; i < 8; i++) pop_one();
      chk(K_TRV, 3'd0, 0, "t4_empty");

      // push and pop with a single entry held
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      ev_push(6'b010000, 0);
      expect_v(K_TRV, 1, "t5_pp_valid");
      tq.push_back({16'd1, 6'b010000});
      step(1'b1, 6'b010000, 1'b0, 1'b0, 1'b1);
      pop_one();
      chk(K_TRV, 3'd0, 0, "t5_empty");

      // snap and clr together at count 5
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) ev_push(6'b100000, i);
      step(1'b1, 6'b100000, 1'b1, 1'b1, 1'b0);
      tq.delete();
      chk(K_RD, 3'd5, 5, "sc_shadow");
      chk(K_RD, 3'd6, 5, "sc_cyc");
      expect_v(K_OVF, 0, "sc_ovf");
      chk(K_TRV, 3'd0, 0, "sc_empty");
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk(K_RD, 3'd5, 0, "sc_live5");
      chk(K_RD, 3'd6, 0, "sc_livecyc");

      // reset mid-burst with 4 entries queued
      for (int i = 0; i < 4; i++) ev_push(6'b000001, i);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk(K_RD, 3'd0, 4, "pre_rst_rd0");
      rd_sel = 3'd0;
      rst = 1'b1;
      expect_v(K_TRV, 0, "arst_trv");
      expect_v(K_RD, 0, "arst_rd");
      expect_v(K_TRD, 0, "arst_trd");
      expect_v(K_OVF, 0, "arst_ovf");
      idle();
      rst = 1'b0;
      tq.delete();
      ev_push(6'b000001, 0);
      ev_push(6'b000001, 1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk(K_RD, 3'd0, 2, "resume_rd0");
      chk(K_RD, 3'd6, 2, "resume_cyc");
      pop_one();
      pop_one();
      chk(K_TRV, 3'd0, 0, "resume_empty");

      idle();
      idle();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/perf_event_monitor.md
PERF_EVENT_MONITOR -- requirements
Module: perf_event_monitor

Interface
REQ-001 The block SHALL have parameter NUM_EV, default 6, the number of event channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 32, the counter width (8..64).
REQ-003 The block SHALL have parameter SAT, default 0: 0 means counters wrap; 1 means counters saturate.
REQ-004 The block SHALL have parameter TR_DEPTH, default 8, the trace FIFO depth (power of two, 2..64).
REQ-005 The block SHALL have parameter TS_W, default 16, the trace timestamp width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have port en, input, 1 bit: counting and trace enable.
REQ-009 The block SHALL have port clr, input, 1 bit: synchronous clear of live counters, FIFO and overflow flag.
REQ-010 The block SHALL have port ev_i, input, NUM_EV bits: per-channel single-cycle event strobes (stall, branch, forwardA, forwardB, ...).
REQ-011 The block SHALL have port snap, input, 1 bit: copy live counters into shadow registers.
REQ-012 The block SHALL have port rd_sel, input, $clog2(NUM_EV+1) bits: shadow select; index NUM_EV selects the cycle counter.
REQ-013 The block SHALL have port rd_data, output, CNT_W bits: the selected shadow value.
REQ-014 The block SHALL have port tr_pop, input, 1 bit: consume the trace head.
REQ-015 The block SHALL have port tr_valid, output, 1 bit: the trace FIFO is non-empty.
REQ-016 The block SHALL have port tr_data, output, TS_W+NUM_EV bits: the head entry, formatted {timestamp, event vector}.
REQ-017 The block SHALL have port tr_ovf, output, 1 bit: sticky trace-overflow flag.

Function
REQ-018 Each cycle with en=1, cycle counter SHALL increment by 1, and each channel counter SHALL increment by 1 where ev_i[i]=1.
REQ-019 With SAT=0, a counter at all-ones SHALL wrap to 0; with SAT=1, it SHALL hold at all-ones.
REQ-020 With en=0, counters and FIFO SHALL hold; ev_i SHALL be ignored.
REQ-021 clr SHALL take priority over increment and push: after the edge, all live counters are 0, the FIFO is empty and tr_ovf=0.
REQ-022 snap SHALL load each shadow with the pre-edge live value, excluding that cycle's increment.
REQ-023 When snap and clr are asserted in the same cycle, the shadows SHALL capture pre-clear values; clr SHALL NOT affect the shadows.
REQ-024 rd_data SHALL be combinational from the shadows; an rd_sel value above NUM_EV SHALL read 0.
REQ-025 A push SHALL occur when en=1 and ev_i is non-zero; the pushed entry SHALL be {cycle_cnt[TS_W-1:0] pre-increment, ev_i}.
REQ-026 The trace FIFO SHALL be first-word fall-through: tr_data is valid while tr_valid=1, and a pushed entry becomes visible on the cycle after the push.
REQ-027 A pop SHALL occur only when tr_pop=1 and tr_valid=1; a pop while empty SHALL be ignored.
REQ-028 A push while full without a same-cycle pop SHALL drop the entry and set tr_ovf, which holds until clr or rst.
REQ-029 A push while full with a same-cycle pop SHALL perform both, with no overflow.
REQ-030 A push and pop while holding one entry SHALL leave the new entry at the head.
REQ-031 Read and write pointers SHALL be $clog2(TR_DEPTH)+1 bits wide, with wrap-around full/empty detection.

Reset
REQ-032 rst=1 SHALL asynchronously zero all live counters, shadows, FIFO pointers and tr_ovf, giving rd_data=0, tr_valid=0 and tr_data=0.
REQ-033 rst asserted mid-operation SHALL discard FIFO contents; counting SHALL resume on the first enabled edge after release.

Structure
REQ-034 Package perf_mon_pkg SHALL hold the event index constants (EV_STALL=0, EV_BRANCH=1, EV_FWDA=2, EV_FWDB=3, EV_LOADUSE=4, EV_FLUSH=5) and the default parameter values.
REQ-035 The trace buffer SHALL be a sub-module, trace_fifo, parametrised by width and depth, with async-high reset and sync clear.

Verification
REQ-036 The bench SHALL drive reset, then en=1 for 10 cycles with ev_i[0] high for 3 of them, then snap; it SHALL require rd_sel=0 → 3 and rd_sel=NUM_EV → 10.
REQ-037 The bench SHALL use CNT_W=8, SAT=0, with ev_i[1] high for 257 cycles, then snap; it SHALL require 1, and with SAT=1 it SHALL require 255.
REQ-038 The bench SHALL drive 9 event cycles with TR_DEPTH=8 and no pop; it SHALL require tr_ovf=1, 8 entries popped with consecutive timestamps, then tr_valid=0.
REQ-039 The bench SHALL drive push and pop together while the FIFO is full; it SHALL require tr_ovf to stay 0 and the count to remain 8.
REQ-040 The bench SHALL drive snap and clr together at counter value 5; it SHALL require shadow=5, live counters=0 and the FIFO empty.
REQ-041 The bench SHALL assert rst mid-burst with 4 entries queued; it SHALL require tr_valid=0 and rd_data=0 immediately, without a clock edge.
